alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have no parameters; data width fixed at 16, register count fixed at 4.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  sequencer can accept a command.
REQ-006 cmd_load  in  1  1 = load immediate; 0 = ALU operation.
REQ-007 cmd_op  in  3  ALU opcode: 0 negate A, 1 A+1, 2 A+B+C, 3 A+(B>>>1), 4 A&B, 5 A|B, 6 {A[7:0],B[7:0]}, 7 zero.
REQ-008 cmd_dst  in  2  destination register index.
REQ-009 cmd_srca  in  2  A-operand register index.
REQ-010 cmd_srcb  in  2  B-operand register index.
REQ-011 cmd_cin  in  1  carry-in C for op 2.
REQ-012 cmd_rpt  in  4  extra iterations; op executes cmd_rpt+1 times.
REQ-013 cmd_imm  in  16  immediate for load.
REQ-014 res_valid  out  1  result available.
REQ-015 res_ready  in  1  consumer takes result.
REQ-016 res_data  out  16  final value written to R[dst].
REQ-017 res_zero  out  1  res_data == 0.
REQ-018 res_neg  out  1  res_data[15].
REQ-019 busy  out  1  state != IDLE.

Function
REQ-020 SHALL hold register file R0..R3, 16 bits each, plus latched command fields and a 4-bit iteration counter.
REQ-021 SHALL implement FSM IDLE, EXEC, DONE; cmd_ready = (state == IDLE).
REQ-022 Accept SHALL occur on cmd_valid && cmd_ready; fields latched that edge; cmd_valid outside IDLE SHALL be ignored, with no effect.
REQ-023 Load accept: R[dst] <= cmd_imm and res_data <= cmd_imm on the accept edge; next state DONE (no EXEC).
REQ-024 ALU accept: counter <= cmd_rpt; next state EXEC.
REQ-025 Each EXEC cycle: W = ALU(R[srca], R[srcb], cin, op) per REQ-007, 16-bit wrap, B>>>1 arithmetic on signed B; R[dst] <= W; res_data <= W.
REQ-026 Operands SHALL be read from current register contents each iteration, so dst == srca/srcb accumulates (e.g. op1, rpt=3 adds 4).
REQ-027 In EXEC: counter == 0 -> DONE; else counter decrements and EXEC repeats; cin is constant across iterations.
REQ-028 Latency: ALU command accepted at edge T produces res_valid high from edge T+rpt+2; load produces it from T+1.
REQ-029 In DONE: res_valid = 1, res_data/res_zero/res_neg stable; res_ready high -> IDLE on that edge; res_ready low -> hold indefinitely.
REQ-030 res_zero and res_neg SHALL derive combinationally from res_data; they are valid only while res_valid is high.
REQ-031 New command SHALL NOT be accepted in the same cycle as a DONE->IDLE transition (one idle cycle minimum between results).

Reset
REQ-032 rst high: state IDLE, R0..R3 = 0, counter = 0, latched fields = 0, res_data = 0; outputs cmd_ready=1, res_valid=0, busy=0, res_zero=1, res_neg=0.
REQ-033 rst SHALL override any in-flight EXEC or DONE; a partial result SHALL be discarded and no res_valid issued.

Structure
REQ-034 Opcode constants (OP_NEG..OP_ZERO), state encodings, and width 16 SHALL be defined in shared package alu_pkg.
REQ-035 The combinational datapath SHALL be one sub-module, alu_core (A, B, C, operator -> W, zero, neg), instantiated once; the sequencer only selects operands and writes back.

Verification
REQ-036 Load R1=16'h0005, then op2 dst=R2 srca=R1 srcb=R1 cin=1 rpt=0 -> res_data 16'h000B, zero=0, neg=0, res_valid at T+2.
REQ-037 Load R0=16'hFFFE; op1 dst=srca=R0 rpt=3 -> four iterations, res_data 16'h0002, res_valid at T+5; wrap through 0 observed.
REQ-038 Load R0=16'h0001; op0 dst=R3 srca=R0 -> res_data 16'hFFFF, neg=1; then op4 R3&R1 (R1=0) -> zero=1.
REQ-039 Hold res_ready=0 for 10 cycles in DONE while driving cmd_valid=1 -> res_valid/res_data stable, no command accepted; release -> IDLE, then accept.
REQ-040 Assert rst during EXEC of rpt=15 command -> next cycle all registers 0, cmd_ready=1, res_valid never asserted.
REQ-041 op6 with R0=16'h12AB, R1=16'h34CD -> res_data 16'hABCD; op7 -> res_data 0, zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: widths, opcodes, FSM states and
// the latched command record.
package alu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned HALF_W = DATA_W / 2;
    localparam int unsigned REG_N  = 4;
    localparam int unsigned REG_AW = 2;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned RPT_W  = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NEG  = 3'd0,   // -A
        OP_INC  = 3'd1,   // A + 1
        OP_ADC  = 3'd2,   // A + B + C
        OP_HALF = 3'd3,   // A + (B >>> 1), B signed
        OP_AND  = 3'd4,   // A & B
        OP_OR   = 3'd5,   // A | B
        OP_PACK = 3'd6,   // {A[7:0], B[7:0]}
        OP_ZERO = 3'd7    // 0
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Command fields held for the duration of a multi-cycle operation.
    typedef struct packed {
        alu_op_e           op;
        logic [REG_AW-1:0] dst;
        logic [REG_AW-1:0] srca;
        logic [REG_AW-1:0] srcb;
        logic              cin;
    } cmd_fields_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath.
// Ports: a, b   - operands
//        c      - carry-in (used by OP_ADC only)
//        op     - operator
//        w      - 16-bit wrapped result
//        zero   - w == 0
//        neg    - w[15]
module alu_core
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              c,
    input  alu_op_e           op,
    output logic [DATA_W-1:0] w,
    output logic              zero,
    output logic              neg
);

    // Result select; all arithmetic wraps at DATA_W bits.
    always_comb begin
        w = '0;
        case (op)
            OP_NEG:  w = DATA_W'(0) - a;
            OP_INC:  w = a + DATA_W'(1);
            OP_ADC:  w = a + b + DATA_W'(c);
            OP_HALF: w = a + DATA_W'($signed(b) >>> 1);
            OP_AND:  w = a & b;
            OP_OR:   w = a | b;
            OP_PACK: w = {a[HALF_W-1:0], b[HALF_W-1:0]};
            OP_ZERO: w = '0;
        endcase
    end

    assign zero = (w == '0);
    assign neg  = w[DATA_W-1];

endmodule

// File: rtl/alu_sequencer.sv
// Four-register ALU sequencer: accepts load or ALU commands, repeats ALU
// operations cmd_rpt+1 times with write-back each cycle, then presents the
// final value until the consumer takes it.
// Ports: clk, rst          - clock, synchronous active-high reset
//        cmd_*             - command handshake and fields
//        res_valid/ready   - result handshake
//        res_data/zero/neg - final value and its flags
//        busy              - sequencer not idle
module alu_sequencer
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [REG_AW-1:0] cmd_dst,
    input  logic [REG_AW-1:0] cmd_srca,
    input  logic [REG_AW-1:0] cmd_srcb,
    input  logic              cmd_cin,
    input  logic [RPT_W-1:0]  cmd_rpt,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              res_neg,
    output logic              busy
);

    seq_state_e        state;
    seq_state_e        next_state;
    cmd_fields_t       cmd_q;
    logic [RPT_W-1:0]  cnt;
    logic [DATA_W-1:0] regs [REG_N];
    logic              accept;
    logic [DATA_W-1:0] alu_w;
    logic              alu_zero;
    logic              alu_neg;

    assign accept = cmd_valid && (state == ST_IDLE);

    // Single shared datapath; operands come from live register contents so
    // dst == src accumulates across iterations.
    alu_core u_core (
        .a    (regs[cmd_q.srca]),
        .b    (regs[cmd_q.srcb]),
        .c    (cmd_q.cin),
        .op   (cmd_q.op),
        .w    (alu_w),
        .zero (alu_zero),
        .neg  (alu_neg)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_state = cmd_load ? ST_DONE : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt == '0) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Register file, command latch, iteration counter and result outputs.
    // Status outputs are registered from next_state so they track state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_N; i++) begin
                regs[i] <= '0;
            end
            cmd_q     <= '0;
            cnt       <= '0;
            res_data  <= '0;
            res_zero  <= 1'b1;
            res_neg   <= 1'b0;
            cmd_ready <= 1'b1;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            cmd_ready <= (next_state == ST_IDLE);
            res_valid <= (next_state == ST_DONE);
            busy      <= (next_state != ST_IDLE);

            if (accept) begin
                cmd_q.op   <= alu_op_e'(cmd_op);
                cmd_q.dst  <= cmd_dst;
                cmd_q.srca <= cmd_srca;
                cmd_q.srcb <= cmd_srcb;
                cmd_q.cin  <= cmd_cin;
                if (cmd_load) begin
                    regs[cmd_dst] <= cmd_imm;
                    res_data      <= cmd_imm;
                    res_zero      <= (cmd_imm == '0);
                    res_neg       <= cmd_imm[DATA_W-1];
                end else begin
                    cnt <= cmd_rpt;
                end
            end

            if (state == ST_EXEC) begin
                regs[cmd_q.dst] <= alu_w;
                res_data        <= alu_w;
                res_zero        <= alu_zero;
                res_neg         <= alu_neg;
                if (cnt != '0) begin
                    cnt <= cnt - RPT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a table of commands with hand-computed
// results and latencies, plus hold, back-to-back and mid-operation reset cases.
module tb_alu_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_load;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_dst;
    logic [1:0]  cmd_srca;
    logic [1:0]  cmd_srcb;
    logic        cmd_cin;
    logic [3:0]  cmd_rpt;
    logic [15:0] cmd_imm;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_zero;
    logic        res_neg;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    alu_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_load  (cmd_load),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_srca  (cmd_srca),
        .cmd_srcb  (cmd_srcb),
        .cmd_cin   (cmd_cin),
        .cmd_rpt   (cmd_rpt),
        .cmd_imm   (cmd_imm),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_zero  (res_zero),
        .res_neg   (res_neg),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          ld;
        logic [2:0]  op;
        logic [1:0]  dst;
        logic [1:0]  sa;
        logic [1:0]  sb;
        bit          cin;
        logic [3:0]  rpt;
        logic [15:0] imm;
        logic [15:0] data;
        bit          z;
        bit          n;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit ld, logic [2:0] op, logic [1:0] dst,
                                logic [1:0] sa, logic [1:0] sb, bit cin,
                                logic [3:0] rpt, logic [15:0] imm,
                                logic [15:0] data, bit z, bit n, int lat);
        vec_t v;
        v.ld = ld; v.op = op; v.dst = dst; v.sa = sa; v.sb = sb; v.cin = cin;
        v.rpt = rpt; v.imm = imm; v.data = data; v.z = z; v.n = n; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        cmd_load = v.ld;
        cmd_op   = v.op;
        cmd_dst  = v.dst;
        cmd_srca = v.sa;
        cmd_srcb = v.sb;
        cmd_cin  = v.cin;
        cmd_rpt  = v.rpt;
        cmd_imm  = v.imm;
    endtask

    // Issue one command, measure the edge at which res_valid is first
    // sampled high (accept edge = 0), check the result, then release it.
    task automatic do_cmd(input vec_t v, input string tag, output bit seen_zero);
        int lat;
        @(negedge clk);
        drive(v);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        seen_zero = 1'b0;
        while (!res_valid && lat < 40) begin
            if (res_data == 16'h0000) seen_zero = 1'b1;
            @(negedge clk);
            lat++;
        end
        chk({tag, " data"}, 32'(res_data), 32'(v.data));
        chk({tag, " zero"}, 32'(res_zero), 32'(v.z));
        chk({tag, " neg"},  32'(res_neg),  32'(v.n));
        chk({tag, " latency"}, 32'(lat), 32'(v.lat));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        bit sz;
        bit ok;
        bit any_valid;

        rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst res_valid", 32'(res_valid), 32'd0);
        chk("rst busy",      32'(busy),      32'd0);
        chk("rst res_zero",  32'(res_zero),  32'd1);
        chk("rst res_neg",   32'(res_neg),   32'd0);
        chk("rst res_data",  32'(res_data),  32'd0);

        //            ld op dst sa sb cin rpt imm       data      z n lat
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 16'h0005, 16'h0005, 0, 0, 1));
        vecs.push_back(mk(0, 2, 2, 1, 1, 1, 0, 16'h0000, 16'h000B, 0, 0, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 16'hFFFE, 16'hFFFE, 0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 3, 16'h0000, 16'h0002, 0, 0, 5));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 16'h0001, 16'h0001, 0, 0, 1));
        vecs.push_back(mk(0, 0, 3, 0, 0, 0, 0, 16'h0000, 16'hFFFF, 0, 1, 2));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 1));
        vecs.push_back(mk(0, 4, 2, 3, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 2));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 16'h12AB, 16'h12AB, 0, 0, 1));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 16'h34CD, 16'h34CD, 0, 0, 1));
        vecs.push_back(mk(0, 6, 2, 0, 1, 0, 0, 16'h0000, 16'hABCD, 0, 1, 2));
        vecs.push_back(mk(0, 7, 3, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 2));
        vecs.push_back(mk(1, 0, 2, 0, 0, 0, 0, 16'h8000, 16'h8000, 0, 1, 1));
        vecs.push_back(mk(0, 3, 3, 0, 2, 0, 0, 16'h0000, 16'hD2AB, 0, 1, 2));
        vecs.push_back(mk(0, 5, 3, 0, 1, 0, 0, 16'h0000, 16'h36EF, 0, 0, 2));
        vecs.push_back(mk(0, 2, 3, 2, 2, 0, 0, 16'h0000, 16'h0000, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h12AB, 0, 0, 3));
        vecs.push_back(mk(0, 3, 1, 0, 1, 1, 0, 16'h0000, 16'h2D11, 0, 0, 2));
        vecs.push_back(mk(0, 2, 2, 0, 1, 1, 2, 16'h0000, 16'h3FBD, 0, 0, 4));

        foreach (vecs[i]) begin
            do_cmd(vecs[i], $sformatf("v%0d", i), sz);
            // FFFE incremented in place four times passes through zero
            if (i == 3) chk("v3 wrap through zero", 32'(sz), 32'd1);
        end

        // Hold in DONE with a competing command offered
        @(negedge clk);
        drive(mk(1, 0, 3, 0, 0, 0, 0, 16'h00A5, 0, 0, 0, 0));
        cmd_valid = 1'b1;
        @(negedge clk);
        drive(mk(1, 0, 0, 0, 0, 0, 0, 16'hFFFF, 0, 0, 0, 0));
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (!(res_valid === 1'b1 && res_data === 16'h00A5 && cmd_ready === 1'b0))
                ok = 1'b0;
            @(negedge clk);
        end
        chk("hold stable", 32'(ok), 32'd1);
        chk("hold data",   32'(res_data), 32'h00A5);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("release idle cmd_ready", 32'(cmd_ready), 32'd1);
        chk("release idle res_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("post-release accept valid", 32'(res_valid), 32'd1);
        chk("post-release accept data",  32'(res_data),  32'hFFFF);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        // R3 must hold the first load, not the held command's immediate
        do_cmd(mk(0, 1, 1, 3, 0, 0, 0, 0, 16'h00A6, 0, 0, 2), "r3 after hold", sz);
        do_cmd(mk(0, 5, 2, 0, 0, 0, 0, 0, 16'hFFFF, 0, 1, 2), "r0 after hold", sz);

        // Reset in the middle of a long repeated operation
        @(negedge clk);
        drive(mk(0, 1, 0, 0, 0, 0, 15, 0, 0, 0, 0, 0));
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("exec busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid rst cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid rst busy",      32'(busy),      32'd0);
        chk("mid rst res_valid", 32'(res_valid), 32'd0);
        chk("mid rst res_data",  32'(res_data),  32'd0);
        chk("mid rst res_zero",  32'(res_zero),  32'd1);
        any_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (res_valid) any_valid = 1'b1;
            @(negedge clk);
        end
        chk("mid rst no res_valid", 32'(any_valid), 32'd0);
        do_cmd(mk(0, 5, 2, 0, 1, 0, 0, 0, 16'h0000, 1, 0, 2), "rst R0|R1", sz);
        do_cmd(mk(0, 5, 0, 2, 3, 0, 0, 0, 16'h0000, 1, 0, 2), "rst R2|R3", sz);
        do_cmd(mk(0, 1, 1, 3, 0, 0, 0, 0, 16'h0001, 0, 0, 2), "rst R3+1", sz);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
